// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state type, fixed register indices, address helper.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] REG_ID       = 32'd0;
  localparam logic [31:0] REG_STATUS   = 32'd1;
  localparam logic [31:0] REG_RW_FIRST = 32'd2;

  // Byte offset to word index; alignment is judged separately from the low bits.
  function automatic logic [31:0] addr_to_index(input logic [31:0] offset);
    return offset >> 2;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 completer-side bus bundle; master drives the i_* signals, the register file drives o_*.
interface apb_slave_regfile_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
) ();

  logic                  i_psel;
  logic                  i_penable;
  logic                  i_pwrite;
  logic [addr_width-1:0] i_paddr;
  logic [data_width-1:0] i_pwdata;
  logic [data_width-1:0] o_prdata;
  logic                  o_pready;
  logic                  o_pslverr;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_prdata, o_pready, o_pslverr
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_prdata, o_pready, o_pslverr
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational decode of a register-bank byte offset into word index and error flags.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic [addr_width-1:0] i_offset,
  input  logic                  i_write,
  output logic [IDX_W-1:0]      o_index,
  output logic                  o_is_id,
  output logic                  o_is_status,
  output logic                  o_misaligned,
  output logic                  o_out_of_range,
  output logic                  o_read_only,
  output logic                  o_err
);

  logic [31:0] word_idx;

  always_comb begin
    word_idx       = addr_to_index(32'(i_offset));
    o_index        = word_idx[IDX_W-1:0];
    o_is_id        = (word_idx == REG_ID);
    o_is_status    = (word_idx == REG_STATUS);
    o_misaligned   = (i_offset[1:0] != 2'b00);
    // Comparing the full word index is the same as offset >= NUM_REGS*4.
    o_out_of_range = (word_idx >= 32'(NUM_REGS));
    o_read_only    = i_write && (word_idx < REG_RW_FIRST);
    o_err          = o_misaligned || o_out_of_range || o_read_only;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a word-addressed register bank, programmable wait states and PSLVERR.
// Register 0 is a constant ID, register 1 mirrors i_hw_status, the rest are read/write.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    addr_width  = 32,
  parameter int                    data_width  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [data_width-1:0] ID_VALUE    = data_width'(32'hA9B0_0001),
  parameter logic [addr_width-1:0] BASE_ADDR   = '0
) (
  input  logic                           i_clk_apb,
  input  logic                           i_rstn_apb,
  apb_slave_regfile_if.slave             bus,
  input  logic [data_width-1:0]          i_hw_status,
  output logic [NUM_REGS*data_width-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [addr_width-1:0] paddr_q, paddr_d;
  logic [data_width-1:0] regs_q [NUM_REGS];
  logic [data_width-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic                  pready;
  logic [data_width-1:0] prdata;
  logic [IDX_W-1:0]      index;
  logic                  is_id, is_status, misaligned, out_of_range, read_only, err;

  apb_addr_decode #(
    .addr_width (addr_width),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_decode (
    .i_offset       (paddr_q - BASE_ADDR),
    .i_write        (pwrite_q),
    .o_index        (index),
    .o_is_id        (is_id),
    .o_is_status    (is_status),
    .o_misaligned   (misaligned),
    .o_out_of_range (out_of_range),
    .o_read_only    (read_only),
    .o_err          (err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    pready     = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        if (!bus.i_psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (bus.i_penable) begin
          pready  = 1'b1;
          state_d = ST_IDLE;
          // Write data comes straight off the bus: APB holds PWDATA stable until PREADY.
          if (pwrite_q && !err) begin
            regs_d[index]     = bus.i_pwdata;
            wr_pulse_d[index] = 1'b1;
          end
        end
      end
      default: begin
        if (bus.i_psel && !bus.i_penable) begin
          state_d  = ST_ACCESS;
          pwrite_d = bus.i_pwrite;
          paddr_d  = bus.i_paddr;
          cnt_d    = 4'(WAIT_STATES);
        end
      end
    endcase
  end

  always_comb begin
    prdata = '0;
    if (pready && !pwrite_q && !err) begin
      if (is_id)          prdata = ID_VALUE;
      else if (is_status) prdata = i_hw_status;
      else                prdata = regs_q[index];
    end
  end

  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Slots 0 and 1 are never written, so they read out as zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) o_regs[i*data_width +: data_width] = regs_q[i];
  end

  assign o_wr_pulse    = wr_pulse_q;
  assign bus.o_pready  = pready;
  assign bus.o_pslverr = pready && err;
  assign bus.o_prdata  = prdata;

endmodule
